// File: rtl/maf_issue_arb_if.sv
// Requester-side and maf-side signal bundle for maf_issue_arb.
// The arbiter uses the slave modport; the requester/maf environment uses master.
interface maf_issue_arb_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 32
);
    logic [N_REQ-1:0]    req_vld;
    logic [N_REQ-1:0]    req_rdy;
    logic [N_REQ*DW-1:0] req_a;
    logic [N_REQ*DW-1:0] req_b;
    logic [N_REQ*DW-1:0] req_c;
    logic [N_REQ-1:0]    rsp_vld;
    logic [DW-1:0]       rsp_res;
    logic                maf_op_vld;
    logic [DW-1:0]       maf_a;
    logic [DW-1:0]       maf_b;
    logic [DW-1:0]       maf_c;
    logic [DW-1:0]       maf_res;
    logic                maf_res_rdy;

    modport master (
        output req_vld, req_a, req_b, req_c, maf_res, maf_res_rdy,
        input  req_rdy, rsp_vld, rsp_res, maf_op_vld, maf_a, maf_b, maf_c
    );

    modport slave (
        input  req_vld, req_a, req_b, req_c, maf_res, maf_res_rdy,
        output req_rdy, rsp_vld, rsp_res, maf_op_vld, maf_a, maf_b, maf_c
    );
endinterface

// File: rtl/maf_issue_arb.sv
// Round-robin issue arbiter sharing one fixed-latency maf unit between N_REQ
// requesters; a tag pipeline routes each result back to its issuing requester.
module maf_issue_arb #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned LAT   = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    maf_issue_arb_if.slave bus,
    output logic           busy,
    output logic           err_sync
);
    localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(LAT + 2);

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_id;
    logic             grant_vld;
    logic [N_REQ-1:0] grant_oh;
    logic             issue;
    logic [DW-1:0]    sel_a;
    logic [DW-1:0]    sel_b;
    logic [DW-1:0]    sel_c;

    logic             op_vld;
    logic [ID_W-1:0]  op_id;
    logic [DW-1:0]    op_a;
    logic [DW-1:0]    op_b;
    logic [DW-1:0]    op_c;

    logic [LAT-1:0]   tag_vld;
    logic [ID_W-1:0]  tag_id [LAT];
    logic [CNT_W-1:0] blank_cnt;
    logic             blank;
    logic             res_hit;
    logic             res_mis;
    logic [N_REQ-1:0] rsp_oh;
    logic [N_REQ-1:0] rsp_vld_q;
    logic [DW-1:0]    rsp_res_q;

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            logic [ID_W-1:0] idx;
            idx = ID_W'((32'(rr_ptr) + k) % N_REQ);
            if (!grant_vld && bus.req_vld[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
        grant_oh = '0;
        if (en && !rst && grant_vld) begin
            grant_oh[grant_id] = 1'b1;
        end
    end

    assign issue = |grant_oh;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                sel_a = bus.req_a[k*DW +: DW];
                sel_b = bus.req_b[k*DW +: DW];
                sel_c = bus.req_c[k*DW +: DW];
            end
        end
    end

    // Results arriving during the post-reset window belong to discarded ops.
    assign blank   = (blank_cnt != '0);
    assign res_hit = !blank && bus.maf_res_rdy && tag_vld[LAT-1];
    assign res_mis = !blank && (bus.maf_res_rdy != tag_vld[LAT-1]);

    always_comb begin
        rsp_oh = '0;
        rsp_oh[tag_id[LAT-1]] = 1'b1;
    end

    // The issue register (op_vld/op_id) sits ahead of tag stage 0, so stage
    // LAT-1 is valid in the same cycle maf raises maf_res_rdy for that op.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            op_vld    <= 1'b0;
            op_id     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_c      <= '0;
            tag_vld   <= '0;
            for (int unsigned k = 0; k < LAT; k++) begin
                tag_id[k] <= '0;
            end
            blank_cnt <= CNT_W'(LAT + 1);
            rsp_vld_q <= '0;
            rsp_res_q <= '0;
            err_sync  <= 1'b0;
        end else begin
            if (issue) begin
                op_vld <= 1'b1;
                op_id  <= grant_id;
                op_a   <= sel_a;
                op_b   <= sel_b;
                op_c   <= sel_c;
                if (32'(grant_id) == N_REQ - 1) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_id + 1'b1;
                end
            end else begin
                op_vld <= 1'b0;
            end

            tag_vld[0] <= op_vld;
            tag_id[0]  <= op_id;
            for (int unsigned k = 1; k < LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end

            if (blank) begin
                blank_cnt <= blank_cnt - 1'b1;
            end

            if (res_hit) begin
                rsp_vld_q <= rsp_oh;
                rsp_res_q <= bus.maf_res;
            end else begin
                rsp_vld_q <= '0;
            end

            if (res_mis) begin
                err_sync <= 1'b1;
            end
        end
    end

    assign bus.req_rdy    = grant_oh;
    assign bus.maf_op_vld = op_vld;
    assign bus.maf_a      = op_a;
    assign bus.maf_b      = op_b;
    assign bus.maf_c      = op_c;
    assign bus.rsp_vld    = rsp_vld_q;
    assign bus.rsp_res    = rsp_res_q;
    assign busy           = op_vld | (|tag_vld);
endmodule
